// File: rtl/spi_seq_pkg.sv
// Shared opcodes, FSM encoding and command-word helpers for the spi_wrapper
// register-access sequencer.
package spi_seq_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_A = 3'd1,
    ST_WAIT_A  = 3'd2,
    ST_ISSUE_D = 3'd3,
    ST_WAIT_D  = 3'd4,
    ST_RESP    = 3'd5
  } seq_state_e;

  function automatic logic [9:0] addr_cmd(input logic write, input logic [7:0] addr);
    return write ? {CMD_WR_ADDR, addr} : {CMD_RD_ADDR, addr};
  endfunction

  // Reads send a zero payload in the data phase; the wrapper returns the byte.
  function automatic logic [9:0] data_cmd(input logic write, input logic [7:0] wdata);
    return write ? {CMD_WR_DATA, wdata} : {CMD_RD_DATA, 8'h00};
  endfunction

endpackage

// File: rtl/spi_seq_timeout_cnt.sv
// Per-phase timeout counter: clear has priority, counts while enabled and
// saturates at TIMEOUT_CYCLES so a stalled wrapper can never make it wrap.
module spi_seq_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/spi_reg_seq.sv
// Turns one register read/write request into the two-phase address/data
// command stream for spi_wrapper and returns data or a timeout error.
module spi_reg_seq
  import spi_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic       i_spi_seq_clk,
  input  logic       i_spi_seq_rst_n,
  input  logic       i_spi_seq_req_valid,
  input  logic       i_spi_seq_req_write,
  input  logic [7:0] i_spi_seq_req_addr,
  input  logic [7:0] i_spi_seq_req_wdata,
  output logic       o_spi_seq_req_ready,
  output logic       o_spi_seq_rsp_valid,
  input  logic       i_spi_seq_rsp_ready,
  output logic [7:0] o_spi_seq_rsp_rdata,
  output logic       o_spi_seq_rsp_err,
  output logic [9:0] o_spi_seq_wr_data,
  output logic       o_spi_seq_wr_start,
  input  logic [7:0] i_spi_seq_wr_data_out,
  input  logic       i_spi_seq_wr_done,
  input  logic       i_spi_seq_wr_busy
);

  seq_state_e state_q, state_d;
  logic       write_q, write_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       req_ready_q, req_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_err_q, rsp_err_d;
  logic [9:0] wr_data_q, wr_data_d;
  logic       wr_start_q, wr_start_d;
  logic       cnt_clr;
  logic       cnt_en;
  logic       cnt_expired;
  logic       done_seen;

  spi_seq_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timeout (
    .clk    (i_spi_seq_clk),
    .rst_n  (i_spi_seq_rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expired(cnt_expired)
  );

  // A done coinciding with our own start pulse belongs to an earlier transfer.
  assign done_seen = i_spi_seq_wr_done && !wr_start_q;

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wr_data_d   = wr_data_q;
    wr_start_d  = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_spi_seq_req_valid && req_ready_q) begin
          write_d = i_spi_seq_req_write;
          addr_d  = i_spi_seq_req_addr;
          wdata_d = i_spi_seq_req_wdata;
          // Issue straight from acceptance when the wrapper is free so start
          // lands in the cycle right after the handshake; ISSUE_A covers busy.
          if (!i_spi_seq_wr_busy) begin
            wr_start_d = 1'b1;
            wr_data_d  = addr_cmd(i_spi_seq_req_write, i_spi_seq_req_addr);
            cnt_clr    = 1'b1;
            state_d    = ST_WAIT_A;
          end else begin
            state_d = ST_ISSUE_A;
          end
        end
      end

      ST_ISSUE_A: begin
        if (!i_spi_seq_wr_busy) begin
          wr_start_d = 1'b1;
          wr_data_d  = addr_cmd(write_q, addr_q);
          cnt_clr    = 1'b1;
          state_d    = ST_WAIT_A;
        end
      end

      ST_WAIT_A: begin
        cnt_en = 1'b1;
        if (done_seen) begin
          state_d = ST_ISSUE_D;
        end else if (cnt_expired) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
          state_d     = ST_RESP;
        end
      end

      ST_ISSUE_D: begin
        if (!i_spi_seq_wr_busy) begin
          wr_start_d = 1'b1;
          wr_data_d  = data_cmd(write_q, wdata_q);
          cnt_clr    = 1'b1;
          state_d    = ST_WAIT_D;
        end
      end

      ST_WAIT_D: begin
        cnt_en = 1'b1;
        if (done_seen) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = write_q ? 8'h00 : i_spi_seq_wr_data_out;
          state_d     = ST_RESP;
        end else if (cnt_expired) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (i_spi_seq_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_spi_seq_clk or negedge i_spi_seq_rst_n) begin
    if (!i_spi_seq_rst_n) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      wr_data_q   <= 10'h000;
      wr_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wr_data_q   <= wr_data_d;
      wr_start_q  <= wr_start_d;
    end
  end

  assign o_spi_seq_req_ready = req_ready_q;
  assign o_spi_seq_rsp_valid = rsp_valid_q;
  assign o_spi_seq_rsp_rdata = rsp_rdata_q;
  assign o_spi_seq_rsp_err   = rsp_err_q;
  assign o_spi_seq_wr_data   = wr_data_q;
  assign o_spi_seq_wr_start  = wr_start_q;

endmodule

// File: tb/tb_spi_reg_seq.sv
// Bench for spi_reg_seq with a behavioural spi_wrapper stand-in (register file,
// fixed latency, optional long busy and never-done modes).
module tb_spi_reg_seq;

  localparam int TO_CYC = 16;
  localparam int LAT    = 4;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [9:0] wr_data;
  logic       wr_start;
  logic [7:0] data_out;
  logic       done;
  logic       busy;

  int errors = 0;
  int checks = 0;

  spi_reg_seq #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(5)) dut (
    .i_spi_seq_clk        (clk),
    .i_spi_seq_rst_n      (rst_n),
    .i_spi_seq_req_valid  (req_valid),
    .i_spi_seq_req_write  (req_write),
    .i_spi_seq_req_addr   (req_addr),
    .i_spi_seq_req_wdata  (req_wdata),
    .o_spi_seq_req_ready  (req_ready),
    .o_spi_seq_rsp_valid  (rsp_valid),
    .i_spi_seq_rsp_ready  (rsp_ready),
    .o_spi_seq_rsp_rdata  (rsp_rdata),
    .o_spi_seq_rsp_err    (rsp_err),
    .o_spi_seq_wr_data    (wr_data),
    .o_spi_seq_wr_start   (wr_start),
    .i_spi_seq_wr_data_out(data_out),
    .i_spi_seq_wr_done    (done),
    .i_spi_seq_wr_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: expected command words and expected {err, rdata} responses.
  logic [9:0] exp_cmd[$];
  logic [8:0] exp_rsp[$];
  int         start_log[$];
  int         cyc = 0;

  // Wrapper stand-in state. mode: 0 normal, 1 long busy after address phase, 2 never done.
  int         mode = 0;
  logic [7:0] mem[256];
  logic [7:0] st_addr;
  logic [9:0] st_cmd;
  int         st_cnt;
  int         st_extra;
  logic       data_done_flag;
  logic       prev_start;
  logic       busy_at_pos;

  always @(posedge clk) busy_at_pos = busy;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      busy = 1'b0; done = 1'b0; st_cnt = 0; st_extra = 0;
      data_done_flag = 1'b0; prev_start = 1'b0;
    end else begin
      if (data_done_flag) chk("rsp_valid_after_done", {31'b0, rsp_valid}, 32'd1);
      if (wr_start) begin
        start_log.push_back(cyc);
        chk("start_while_busy", {31'b0, busy_at_pos}, 32'd0);
        chk("start_width", {31'b0, prev_start}, 32'd0);
        if (exp_cmd.size() == 0) begin
          checks++; errors++;
          $error("FAIL start_unexpected: observed=%0h expected=none", wr_data);
        end else begin
          chk("cmd_word", {22'b0, wr_data}, {22'b0, exp_cmd.pop_front()});
        end
      end
      prev_start = wr_start;

      data_done_flag = 1'b0;
      done = 1'b0;
      if (st_extra > 0) begin
        st_extra--;
        if (st_extra == 0) busy = 1'b0;
      end else if (st_cnt > 0) begin
        st_cnt--;
        if (st_cnt == 0) begin
          done = 1'b1;
          case (st_cmd[9:8])
            2'b00, 2'b10: st_addr = st_cmd[7:0];
            2'b01: mem[st_addr] = st_cmd[7:0];
            default: data_out = mem[st_addr];
          endcase
          data_done_flag = st_cmd[8];
          if (mode == 1 && !st_cmd[8]) st_extra = 20;
          else busy = 1'b0;
        end
      end
      if (wr_start && mode != 2) begin
        st_cmd = wr_data;
        busy   = 1'b1;
        st_cnt = LAT;
      end
    end
  end

  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input logic exp_err, input int ncmd);
    int n;
    exp_cmd.push_back(w ? {2'b00, a} : {2'b10, a});
    if (ncmd > 1) exp_cmd.push_back(w ? {2'b01, d} : {2'b11, 8'h00});
    exp_rsp.push_back({exp_err, exp_rd});
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept_bound", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("start_latency", {31'b0, wr_start}, 32'd1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrive_bound", {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic take_rsp();
    logic [8:0] e;
    e = (exp_rsp.size() != 0) ? exp_rsp.pop_front() : 9'h1FF;
    chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, e[7:0]});
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, e[8]});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_clear", {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic collect(output int lat);
    wait_rsp(lat);
    take_rsp();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, {24'b0, rsp_rdata}, 32'd0);
    chk({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
    chk({tag, "_wr_start"}, {31'b0, wr_start}, 32'd0);
    chk({tag, "_wr_data"}, {22'b0, wr_data}, 32'd0);
  endtask

  initial begin
    int lat;
    int sz;
    foreach (mem[i]) mem[i] = 8'h00;
    data_out = 8'h00; busy = 1'b0; done = 1'b0; st_addr = 8'h00; st_cmd = 10'h000;
    st_cnt = 0; st_extra = 0; data_done_flag = 1'b0; prev_start = 1'b0; busy_at_pos = 1'b0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    #1 chk("release_req_ready_low", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("release_req_ready_high", {31'b0, req_ready}, 32'd1);

    // Write then read back several address/data pairs.
    issue(1'b1, 8'h10, 8'hAA, 8'h00, 1'b0, 2); collect(lat);
    issue(1'b0, 8'h10, 8'h00, 8'hAA, 1'b0, 2); collect(lat);
    issue(1'b1, 8'h20, 8'h55, 8'h00, 1'b0, 2); collect(lat);
    issue(1'b0, 8'h20, 8'h00, 8'h55, 1'b0, 2); collect(lat);
    issue(1'b1, 8'h30, 8'hFF, 8'h00, 1'b0, 2); collect(lat);
    issue(1'b0, 8'h30, 8'h00, 8'hFF, 1'b0, 2); collect(lat);
    issue(1'b1, 8'h40, 8'h00, 8'h00, 1'b0, 2); collect(lat);
    issue(1'b0, 8'h40, 8'h00, 8'h00, 1'b0, 2); collect(lat);
    chk("wr_data_held", {22'b0, wr_data}, 32'h300);

    // Wrapper stays busy for 20 cycles after the address-phase done.
    mode = 1;
    sz = start_log.size();
    issue(1'b1, 8'h50, 8'h66, 8'h00, 1'b0, 2); collect(lat);
    chk("busy_hold_gap", start_log[sz+1] - start_log[sz], LAT + 21);
    mode = 0;
    issue(1'b0, 8'h50, 8'h00, 8'h66, 1'b0, 2); collect(lat);

    // Wrapper never signals done: address phase times out, no data phase.
    mode = 2;
    issue(1'b0, 8'h60, 8'h00, 8'h00, 1'b1, 1); collect(lat);
    chk("timeout_latency", lat, TO_CYC + 1);
    mode = 0;
    repeat (3) @(negedge clk);

    // Response back-pressure with the next request already pending.
    issue(1'b0, 8'h20, 8'h00, 8'h55, 1'b0, 2);
    wait_rsp(lat);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h70; req_wdata = 8'h77;
    for (int i = 0; i < 10; i++) begin
      chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_rsp_rdata", {24'b0, rsp_rdata}, 32'h55);
      chk("stall_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    take_rsp();
    issue(1'b1, 8'h70, 8'h77, 8'h00, 1'b0, 2); collect(lat);
    issue(1'b0, 8'h70, 8'h00, 8'h77, 1'b0, 2); collect(lat);

    // Reset while waiting for the data phase to finish.
    sz = start_log.size();
    issue(1'b0, 8'h30, 8'h00, 8'hFF, 1'b0, 2);
    lat = 0;
    while (start_log.size() < sz + 2 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("reach_wait_d", start_log.size(), sz + 2);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    exp_rsp.delete();
    exp_cmd.delete();
    repeat (2) @(negedge clk);
    chk_reset_outputs("held_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_req_ready", {31'b0, req_ready}, 32'd1);
    issue(1'b0, 8'h30, 8'h00, 8'hFF, 1'b0, 2); collect(lat);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
